// File: rtl/sysmon_frame_pkg.sv
// Shared frame layout constants and FSM state type for the sysmon frame packer.
package sysmon_frame_pkg;
    localparam int FRAME_LEN = 31;
    localparam int SEQ_IDX   = 2;
    localparam int MEAS_IDX  = 3;
    localparam int ALM_IDX   = 19;
    localparam int FLAG_IDX  = 21;
    localparam int DNA_IDX   = 22;
    localparam int CHK_IDX   = FRAME_LEN - 1;
    localparam int NUM_MEAS  = 8;

    typedef enum logic {IDLE, SEND} state_e;
    typedef logic [4:0] idx_t;
endpackage

// File: rtl/sysmon_frame_if.sv
// Byte-wide valid/ready stream carrying the packed sysmon frame.
interface sysmon_frame_if;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/sysmon_frame_chk.sv
// Per-byte frame checksum step: modulo-256 sum, or CRC-8 (poly 0x07, MSB first)
// when SYSMON_FRAME_CRC_EN is defined.
module sysmon_frame_chk (
    input  logic [7:0] i_acc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_acc
);
`ifdef SYSMON_FRAME_CRC_EN
    logic [7:0] w_c;

    always_comb begin
        w_c = i_acc ^ i_byte;
        for (int b = 0; b < 8; b++) begin
            w_c = w_c[7] ? ((w_c << 1) ^ 8'h07) : (w_c << 1);
        end
        o_acc = w_c;
    end
`else
    assign o_acc = i_acc + i_byte;
`endif
endmodule

// File: rtl/sysmon_frame_packer.sv
// Snapshots XADC sensor words, alarms and device DNA and streams them as a 31-byte
// checksummed frame. Checksum flavour is selected by SYSMON_FRAME_CRC_EN.
module sysmon_frame_packer
    import sysmon_frame_pkg::*;
#(
    parameter int         PERIOD_CYCLES = 10_000_000,
    parameter logic [7:0] HDR0          = 8'hA5,
    parameter logic [7:0] HDR1          = 8'h5A
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [15:0]           meas_temp,
    input  logic [15:0]           meas_vccint,
    input  logic [15:0]           meas_vccaux,
    input  logic [15:0]           meas_vccbram,
    input  logic [15:0]           meas_aux0,
    input  logic [15:0]           meas_aux1,
    input  logic [15:0]           meas_aux2,
    input  logic [15:0]           meas_aux3,
    input  logic [15:0]           alm,
    input  logic                  dna_valid,
    input  logic [56:0]           dna_data,
    input  logic                  snap_req,
    sysmon_frame_if.master        m_axis,
    output logic                  busy,
    output logic [7:0]            seq,
    output logic [7:0]            overrun_cnt
);
    state_e                        r_state;
    logic [31:0]                   r_pcnt;
    idx_t                          r_idx;
    logic [7:0]                    r_acc;
    logic [7:0]                    r_tdata;
    logic                          r_tvalid;
    logic                          r_tlast;
    logic [7:0]                    r_seq;
    logic [7:0]                    r_ovr;

    logic [NUM_MEAS-1:0][15:0]     r_meas;
    logic [15:0]                   r_alm;
    logic                          r_dna_valid;
    logic [56:0]                   r_dna;

    logic                          w_tick;
    logic                          w_trig;
    logic                          w_cap;
    logic                          w_hs;
    idx_t                          w_nidx;
    logic [7:0]                    w_acc_nxt;
    logic [63:0]                   w_dna64;
    logic [7:0]                    w_frame [0:31];

    assign w_tick = (PERIOD_CYCLES != 0) && (r_pcnt == 32'(PERIOD_CYCLES - 1));
    assign w_trig = snap_req | w_tick;
    assign w_cap  = (r_state == IDLE) && w_trig;
    assign w_hs   = r_tvalid && m_axis.m_tready;
    assign w_nidx = r_idx + idx_t'(1);

    sysmon_frame_chk u_chk (
        .i_acc  (r_acc),
        .i_byte (r_tdata),
        .o_acc  (w_acc_nxt)
    );

    // Snapshot is taken on the triggering edge and held for the whole frame.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_meas      <= {meas_aux3, meas_aux2, meas_aux1, meas_aux0,
                            meas_vccbram, meas_vccaux, meas_vccint, meas_temp};
            r_alm       <= alm;
            r_dna_valid <= dna_valid;
            r_dna       <= dna_data;
        end
    end

    assign w_dna64 = {7'b0, r_dna};

    always_comb begin
        for (int i = 0; i < 32; i++) w_frame[i] = '0;
        w_frame[0]       = HDR0;
        w_frame[1]       = HDR1;
        w_frame[SEQ_IDX] = r_seq;
        for (int m = 0; m < NUM_MEAS; m++) begin
            w_frame[MEAS_IDX + 2*m]     = r_meas[m][15:8];
            w_frame[MEAS_IDX + 2*m + 1] = r_meas[m][7:0];
        end
        w_frame[ALM_IDX]     = r_alm[15:8];
        w_frame[ALM_IDX + 1] = r_alm[7:0];
        w_frame[FLAG_IDX]    = {7'b0, r_dna_valid};
        for (int k = 0; k < 8; k++) begin
            w_frame[DNA_IDX + k] = w_dna64[63 - 8*k -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_pcnt   <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_seq    <= '0;
            r_ovr    <= '0;
        end else begin
            if (w_tick || PERIOD_CYCLES == 0) r_pcnt <= '0;
            else                              r_pcnt <= r_pcnt + 32'd1;

            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_state  <= SEND;
                        r_idx    <= '0;
                        r_acc    <= '0;
                        r_tdata  <= HDR0;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                    end
                end
                SEND: begin
                    if (w_trig && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
                    if (w_hs) begin
                        if (r_idx == idx_t'(CHK_IDX)) begin
                            r_state  <= IDLE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_seq    <= r_seq + 8'd1;
                        end else begin
                            // The checksum byte is the accumulator after folding in byte 29.
                            r_idx   <= w_nidx;
                            r_acc   <= w_acc_nxt;
                            r_tdata <= (w_nidx == idx_t'(CHK_IDX)) ? w_acc_nxt : w_frame[w_nidx];
                            r_tlast <= (w_nidx == idx_t'(CHK_IDX));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axis.m_tdata  = r_tdata;
    assign m_axis.m_tvalid = r_tvalid;
    assign m_axis.m_tlast  = r_tlast;
    assign busy            = (r_state == SEND);
    assign seq             = r_seq;
    assign overrun_cnt     = r_ovr;
endmodule

// File: tb/tb_sysmon_frame_packer.sv
// Self-checking bench for sysmon_frame_packer: checksum step table, frame scoreboard
// with random data and backpressure, overrun counting, periodic trigger and reset abort.
module tb_sysmon_frame_packer;
    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] acc; logic [7:0] byt; logic [7:0] exp; } cvec_t;

    logic        clk = 1'b0;
    logic        resetn, rp_n, snap_req, rdy, dv;
    logic [15:0] mv [0:7];
    logic [15:0] alm;
    logic [56:0] dna;
    logic        busy, busy_p;
    logic [7:0]  seq, seq_p, ovr, ovr_p;
    logic [7:0]  c_acc, c_byte, c_out;

    int errs = 0;
    int checks = 0;
    int m_seq = 0;
    int m_ovr = 0;
    logic [8:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_b = '0;

    always #5 clk = ~clk;

    sysmon_frame_if sif();
    sysmon_frame_if pif();
    assign sif.m_tready = rdy;
    assign pif.m_tready = 1'b1;

    sysmon_frame_packer #(.PERIOD_CYCLES(0)) u_dut (
        .clk(clk), .resetn(resetn),
        .meas_temp(mv[0]), .meas_vccint(mv[1]), .meas_vccaux(mv[2]), .meas_vccbram(mv[3]),
        .meas_aux0(mv[4]), .meas_aux1(mv[5]), .meas_aux2(mv[6]), .meas_aux3(mv[7]),
        .alm(alm), .dna_valid(dv), .dna_data(dna), .snap_req(snap_req),
        .m_axis(sif.master), .busy(busy), .seq(seq), .overrun_cnt(ovr)
    );

    sysmon_frame_packer #(.PERIOD_CYCLES(64)) u_dp (
        .clk(clk), .resetn(rp_n),
        .meas_temp(mv[0]), .meas_vccint(mv[1]), .meas_vccaux(mv[2]), .meas_vccbram(mv[3]),
        .meas_aux0(mv[4]), .meas_aux1(mv[5]), .meas_aux2(mv[6]), .meas_aux3(mv[7]),
        .alm(alm), .dna_valid(dv), .dna_data(dna), .snap_req(1'b0),
        .m_axis(pif.master), .busy(busy_p), .seq(seq_p), .overrun_cnt(ovr_p)
    );

    sysmon_frame_chk u_chk (.i_acc(c_acc), .i_byte(c_byte), .o_acc(c_out));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

`ifdef SYSMON_FRAME_CRC_EN
    // Bit-serial LFSR view of CRC-8/0x07.
    function automatic logic [7:0] ref_step(input logic [7:0] c, input logic [7:0] d);
        logic fb;
        for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ d[b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`else
    function automatic logic [7:0] ref_step(input logic [7:0] c, input logic [7:0] d);
        return 8'((int'(c) + int'(d)) % 256);
    endfunction
`endif

    function automatic logic [7:0] ref_chk(input bq_t q);
        logic [7:0] c = 8'h00;
        foreach (q[i]) c = ref_step(c, q[i]);
        return c;
    endfunction

    // Handshake monitor plus stall-stability check on the main DUT.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", 32'(sif.m_tvalid), 32'd1);
            chk("stall_data", 32'({sif.m_tlast, sif.m_tdata}), 32'(prev_b));
        end
        if (resetn && sif.m_tvalid && rdy) rx_q.push_back({sif.m_tlast, sif.m_tdata});
        prev_stall = resetn && sif.m_tvalid && !rdy;
        prev_b     = {sif.m_tlast, sif.m_tdata};
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 8; i++) mv[i] = 16'($urandom);
        alm = 16'($urandom);
        dv  = 1'($urandom);
        dna = 57'({$urandom, $urandom});
    endtask

    task automatic build_exp();
        logic [63:0] d;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(m_seq));
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mv[i][15:8]);
            exp_q.push_back(mv[i][7:0]);
        end
        exp_q.push_back(alm[15:8]);
        exp_q.push_back(alm[7:0]);
        exp_q.push_back({7'b0, dv});
        d = {7'b0, dna};
        for (int k = 0; k < 8; k++) exp_q.push_back(d[63 - 8*k -: 8]);
        exp_q.push_back(ref_chk(exp_q));
    endtask

    task automatic start_frame(input string nm);
        build_exp();
        rx_q.delete();
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        @(negedge clk);
        chk({nm, "_lat_valid"}, 32'(sif.m_tvalid), 32'd1);
        chk({nm, "_lat_busy"}, 32'(busy), 32'd1);
        chk({nm, "_lat_hdr"}, 32'(sif.m_tdata), 32'hA5);
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low 20 cycles then random
    task automatic drain(input string nm, input int mode);
        int n = 0;
        while (rx_q.size() < 31 && n < 3000) begin
            step(1);
            n++;
            rand_inputs();
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom);
                default: rdy = (n > 20) ? 1'($urandom) : 1'b0;
            endcase
        end
        rdy = 1'b1;
        step(5);
        @(negedge clk);
        chk({nm, "_len"}, 32'(rx_q.size()), 32'd31);
        for (int i = 0; i < rx_q.size() && i < 31; i++) begin
            chk($sformatf("%s_b%0d", nm, i), 32'(rx_q[i][7:0]), 32'(exp_q[i]));
            chk($sformatf("%s_last%0d", nm, i), 32'(rx_q[i][8]), 32'(i == 30));
        end
        m_seq = (m_seq + 1) % 256;
        chk({nm, "_seq"}, 32'(seq), 32'(m_seq));
        chk({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        cvec_t tbl[12];
        logic [7:0] acc;
        bq_t fq;
        logic [8:0] pq[$];
        int n, lasts;
        logic saw_low;
        string s9 = "123456789";

        tbl[0] = '{8'h00, 8'h31, 8'h00};
        tbl[1] = '{8'hFF, 8'h01, 8'h00};
        tbl[2] = '{8'h80, 8'h00, 8'h00};
        tbl[3] = '{8'h00, 8'h00, 8'h00};
        for (int i = 4; i < 12; i++) tbl[i] = '{8'($urandom), 8'($urandom), 8'h00};
        for (int i = 0; i < 12; i++) tbl[i].exp = ref_step(tbl[i].acc, tbl[i].byt);

        resetn = 1'b0; rp_n = 1'b0; snap_req = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 8; i++) mv[i] = '0;
        alm = '0; dv = 1'b0; dna = '0;
        c_acc = '0; c_byte = '0;

        for (int i = 0; i < 12; i++) begin
            c_acc = tbl[i].acc; c_byte = tbl[i].byt; #1;
            chk($sformatf("chk_tbl%0d", i), 32'(c_out), 32'(tbl[i].exp));
        end
        acc = 8'h00;
        for (int i = 0; i < 9; i++) begin
            c_acc = acc; c_byte = s9[i]; #1;
            acc = c_out;
        end
`ifdef SYSMON_FRAME_CRC_EN
        chk("chk_check_str", 32'(acc), 32'hF4);
`else
        chk("chk_check_str", 32'(acc), 32'hDD);
`endif

        step(3);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", 32'(sif.m_tvalid), 32'd0);
        chk("rst_tlast", 32'(sif.m_tlast), 32'd0);
        chk("rst_tdata", 32'(sif.m_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_seq", 32'(seq), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);

        // All-zero frame
        step(1);
        start_frame("t1");
        drain("t1", 0);
`ifndef SYSMON_FRAME_CRC_EN
        chk("t1_sum", 32'(rx_q[30][7:0]), 32'hFF);
`endif

        // Known vector
        for (int i = 0; i < 8; i++) mv[i] = '0;
        mv[0] = 16'h1234; alm = '0; dv = 1'b1; dna = 57'h1_2345_6789_ABCD;
        start_frame("t2");
        drain("t2", 0);
        chk("t2_b3", 32'(rx_q[3][7:0]), 32'h12);
        chk("t2_b4", 32'(rx_q[4][7:0]), 32'h34);
        chk("t2_b21", 32'(rx_q[21][7:0]), 32'h01);
        chk("t2_b23", 32'(rx_q[23][7:0]), 32'h01);
        chk("t2_b29", 32'(rx_q[29][7:0]), 32'hCD);

        // Random data with random backpressure
        for (int f = 0; f < 6; f++) begin
            rand_inputs();
            start_frame($sformatf("t3r%0d", f));
            drain($sformatf("t3r%0d", f), 1);
        end
        rand_inputs();
        rdy = 1'b0;
        start_frame("t3h");
        drain("t3h", 2);

        // Overrun: three extra requests, then a long burst to saturate
        rand_inputs();
        rdy = 1'b0;
        start_frame("t4a");
        for (int i = 0; i < 3; i++) begin
            snap_req = 1'b1; step(1); snap_req = 1'b0; step(1);
        end
        m_ovr += 3;
        @(negedge clk);
        chk("t4_ovr3", 32'(ovr), 32'(m_ovr));
        drain("t4a", 0);

        rand_inputs();
        rdy = 1'b0;
        build_exp();
        rx_q.delete();
        snap_req = 1'b1;
        step(301);
        snap_req = 1'b0;
        m_ovr = (m_ovr + 300 > 255) ? 255 : m_ovr + 300;
        @(negedge clk);
        chk("t4_ovr_sat", 32'(ovr), 32'(m_ovr));
        drain("t4b", 0);
        chk("t4_ovr_hold", 32'(ovr), 32'd255);

        // Periodic trigger on the second instance
        step(1);
        rp_n = 1'b1;
        n = 0;
        do begin step(1); n++; @(negedge clk); end while (!pif.m_tvalid && n < 200);
        chk("t5_first", 32'(n), 32'd64);
        chk("t5_seq0", 32'(seq_p), 32'd0);
        for (int f = 1; f < 3; f++) begin
            n = 0; saw_low = 1'b0;
            do begin
                step(1); n++; @(negedge clk);
                if (!pif.m_tvalid) saw_low = 1'b1;
            end while (!(saw_low && pif.m_tvalid) && n < 200);
            chk($sformatf("t5_period%0d", f), 32'(n), 32'd64);
            chk($sformatf("t5_seq%0d", f), 32'(seq_p), 32'(f));
        end
        step(10);
        rp_n = 1'b0;
        step(1);
        @(negedge clk);
        chk("t5_rst_valid", 32'(pif.m_tvalid), 32'd0);
        chk("t5_rst_last", 32'(pif.m_tlast), 32'd0);
        chk("t5_rst_seq", 32'(seq_p), 32'd0);
        chk("t5_rst_busy", 32'(busy_p), 32'd0);
        step(1);
        rp_n = 1'b1;
        n = 0;
        do begin step(1); n++; @(negedge clk); end while (!pif.m_tvalid && n < 200);
        chk("t5_restart", 32'(n), 32'd64);
        pq.delete();
        pq.push_back({pif.m_tlast, pif.m_tdata});
        for (int j = 1; j < 31; j++) begin
            step(1); @(negedge clk);
            pq.push_back({pif.m_tlast, pif.m_tdata});
        end
        fq.delete();
        lasts = 0;
        for (int j = 0; j < 31; j++) begin
            if (j < 30) fq.push_back(pq[j][7:0]);
            if (pq[j][8]) lasts++;
        end
        chk("t5_hdr0", 32'(pq[0][7:0]), 32'hA5);
        chk("t5_hdr1", 32'(pq[1][7:0]), 32'h5A);
        chk("t5_seqb", 32'(pq[2][7:0]), 32'h00);
        chk("t5_chk", 32'(pq[30][7:0]), 32'(ref_chk(fq)));
        chk("t5_lastcnt", 32'(lasts), 32'd1);
        chk("t5_last30", 32'(pq[30][8]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
